// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int REG_ZERO     = 0;

    function automatic int addr_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read / writeback / issue bus of the scoreboarded register file.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = addr_w(NUM_REGS_DEF)
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              busy1;
    logic              busy2;
    logic              hazard;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              flush;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data1, rd_data2, busy1, busy2, hazard
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data1, rd_data2, busy1, busy2, hazard
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending flag per nonzero register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    localparam int ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              busy1,
    output logic              busy2
);

    logic [NUM_REGS-1:1] busy_q;
    logic [NUM_REGS-1:1] busy_d;
    logic [NUM_REGS-1:0] busy_all;

    // Later assignments win: issue set beats flush, flush beats writeback clear.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i)))
                busy_d[i] = 1'b0;
            if (flush)
                busy_d[i] = 1'b0;
            if (iss_en && (iss_addr == ADDR_W'(i)))
                busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    // Register 0 reads as never busy.
    assign busy_all = {busy_q, 1'b0};
    assign busy1    = busy_all[rd_addr1];
    assign busy2    = busy_all[rd_addr2];

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with busy scoreboard and hazard detection.
// Optional write-through forwarding is enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input logic         clk,
    input logic         reset,
    regfile_sb_if.slave bus
);

    localparam int ADDR_W = addr_w(NUM_REGS);

    logic [DATA_W-1:0] mem [1:NUM_REGS-1];
    logic              wr_valid;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;
    logic              sb_busy1;
    logic              sb_busy2;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              busy1;
    logic              busy2;

    assign wr_valid = bus.wr_en && (bus.wr_addr != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NUM_REGS; i++)
                mem[i] <= '0;
        end else if (wr_valid) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign stored1 = (bus.rd_addr1 == ADDR_W'(REG_ZERO)) ? '0 : mem[bus.rd_addr1];
    assign stored2 = (bus.rd_addr2 == ADDR_W'(REG_ZERO)) ? '0 : mem[bus.rd_addr2];

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .flush    (bus.flush),
        .rd_addr1 (bus.rd_addr1),
        .rd_addr2 (bus.rd_addr2),
        .busy1    (sb_busy1),
        .busy2    (sb_busy2)
    );

    always_comb begin
        data1 = stored1;
        data2 = stored2;
        busy1 = sb_busy1;
        busy2 = sb_busy2;
`ifdef REGFILE_SB_BYPASS_EN
        // A same-cycle issue to the written register is a new producer, so it stays busy.
        if (wr_valid && (bus.rd_addr1 == bus.wr_addr)) begin
            data1 = bus.wr_data;
            busy1 = bus.iss_en && (bus.iss_addr == bus.wr_addr);
        end
        if (wr_valid && (bus.rd_addr2 == bus.wr_addr)) begin
            data2 = bus.wr_data;
            busy2 = bus.iss_en && (bus.iss_addr == bus.wr_addr);
        end
`endif
    end

    assign bus.rd_data1 = data1;
    assign bus.rd_data2 = data2;
    assign bus.busy1    = busy1;
    assign bus.busy2    = busy2;
    assign bus.hazard   = busy1 | busy2;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus a randomized run against an array model.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [DW-1:0] m_data [NR];
    bit            m_busy [NR];

    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_sb #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
        if (bus.wr_en && bus.wr_addr != 0 && bus.wr_addr == a) return bus.wr_data;
`endif
        return m_data[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
        if (bus.wr_en && bus.wr_addr != 0 && bus.wr_addr == a)
            return bus.iss_en && (bus.iss_addr == a);
`endif
        return m_busy[a];
    endfunction

    task automatic drive_idle();
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.flush    = 1'b0;
        reset        = 1'b0;
    endtask

    // One rising edge: the model consumes the same inputs the DUT sees, then settle at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                m_data[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (bus.wr_en && bus.wr_addr != 0) begin
                m_data[bus.wr_addr] = bus.wr_data;
                m_busy[bus.wr_addr] = 1'b0;
            end
            if (bus.flush)
                for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
            if (bus.iss_en && bus.iss_addr != 0)
                m_busy[bus.iss_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_idle();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
        tick();
        drive_idle();
        bus.rd_addr1 = 5'd5;
        #1;
        n_checks++;
        if (bus.rd_data1 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL pre_reset_r5: got %h expected %h", bus.rd_data1, 32'hDEADBEEF);
        end
        // Reset must override simultaneous write and issue.
        reset = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'h1111_2222;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd5;
        tick();
        drive_idle();
        bus.rd_addr1 = 5'd5;
        #1;
        n_checks++;
        if (bus.rd_data1 !== 32'h0) begin
            n_fail++; $display("FAIL reset_data_r5: got %h expected %h", bus.rd_data1, 32'h0);
        end
        n_checks++;
        if (bus.busy1 !== 1'b0 || bus.hazard !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_r5: got busy=%b hazard=%b expected 0 0", bus.busy1, bus.hazard);
        end
    endtask

    task automatic test_issue_write();
        drive_idle();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
        tick();
        drive_idle();
        bus.rd_addr1 = 5'd7; bus.rd_addr2 = 5'd0;
        #1;
        n_checks++;
        if (bus.busy1 !== 1'b1 || bus.hazard !== 1'b1) begin
            n_fail++; $display("FAIL issue_busy_r7: got busy=%b hazard=%b expected 1 1", bus.busy1, bus.hazard);
        end
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h1234;
        tick();
        drive_idle();
        #1;
        n_checks++;
        if (bus.rd_data1 !== 32'h1234 || bus.busy1 !== 1'b0 || bus.hazard !== 1'b0) begin
            n_fail++; $display("FAIL writeback_r7: got data=%h busy=%b hazard=%b expected 00001234 0 0",
                               bus.rd_data1, bus.busy1, bus.hazard);
        end
    endtask

    task automatic test_same_addr();
        drive_idle();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hA5A5;
        tick();
        drive_idle();
        bus.rd_addr1 = 5'd0; bus.rd_addr2 = 5'd3;
        #1;
        n_checks++;
        if (bus.rd_data2 !== 32'hA5A5 || bus.busy2 !== 1'b1 || bus.hazard !== 1'b1) begin
            n_fail++; $display("FAIL same_addr_r3: got data=%h busy=%b hazard=%b expected 0000a5a5 1 1",
                               bus.rd_data2, bus.busy2, bus.hazard);
        end
    endtask

    task automatic test_r0();
        drive_idle();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFFFFFF;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        bus.rd_addr1 = 5'd0; bus.rd_addr2 = 5'd0;
        #1;
        n_checks++;
        if (bus.rd_data1 !== 32'h0 || bus.busy1 !== 1'b0) begin
            n_fail++; $display("FAIL r0_same_cycle: got data=%h busy=%b expected 0 0", bus.rd_data1, bus.busy1);
        end
        tick();
        drive_idle();
        #1;
        n_checks++;
        if (bus.rd_data1 !== 32'h0 || bus.busy1 !== 1'b0 || bus.hazard !== 1'b0) begin
            n_fail++; $display("FAIL r0_next_cycle: got data=%h busy=%b hazard=%b expected 0 0 0",
                               bus.rd_data1, bus.busy1, bus.hazard);
        end
    endtask

    task automatic test_flush();
        drive_idle();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd1;
        tick();
        bus.iss_addr = 5'd2;
        tick();
        drive_idle();
        bus.rd_addr1 = 5'd1; bus.rd_addr2 = 5'd2;
        #1;
        n_checks++;
        if (bus.busy1 !== 1'b1 || bus.busy2 !== 1'b1) begin
            n_fail++; $display("FAIL pre_flush_busy: got %b %b expected 1 1", bus.busy1, bus.busy2);
        end
        // Flush alongside an issue to r4 and a write to r6.
        bus.flush = 1'b1;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd6; bus.wr_data = 32'h66;
        tick();
        drive_idle();
        bus.rd_addr1 = 5'd1; bus.rd_addr2 = 5'd2;
        #1;
        n_checks++;
        if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin
            n_fail++; $display("FAIL flush_cleared: got %b %b expected 0 0", bus.busy1, bus.busy2);
        end
        bus.rd_addr1 = 5'd4; bus.rd_addr2 = 5'd6;
        #1;
        n_checks++;
        if (bus.busy1 !== 1'b1 || bus.rd_data2 !== 32'h66 || bus.busy2 !== 1'b0) begin
            n_fail++; $display("FAIL flush_issue_write: got busy4=%b data6=%h busy6=%b expected 1 00000066 0",
                               bus.busy1, bus.rd_data2, bus.busy2);
        end
    endtask

    task automatic test_raw_timing();
        logic [DW-1:0] same_exp;
        drive_idle();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h11;
        tick();
        drive_idle();
        bus.rd_addr1 = 5'd9;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h55;
`ifdef REGFILE_SB_BYPASS_EN
        same_exp = 32'h55;
`else
        same_exp = 32'h11;
`endif
        #1;
        n_checks++;
        if (bus.rd_data1 !== same_exp) begin
            n_fail++; $display("FAIL raw_same_cycle_r9: got %h expected %h", bus.rd_data1, same_exp);
        end
        tick();
        drive_idle();
        bus.rd_addr1 = 5'd9;
        #1;
        n_checks++;
        if (bus.rd_data1 !== 32'h55) begin
            n_fail++; $display("FAIL raw_next_cycle_r9: got %h expected %h", bus.rd_data1, 32'h55);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e1, e2;
        logic          b1, b2;
        for (int n = 0; n < 400; n++) begin
            drive_idle();
            reset        = ($urandom_range(0, 49) == 0);
            bus.flush    = ($urandom_range(0, 9) == 0);
            bus.wr_en    = ($urandom_range(0, 1) == 1);
            bus.iss_en   = ($urandom_range(0, 1) == 1);
            bus.wr_addr  = AW'($urandom_range(0, 7));
            bus.iss_addr = AW'($urandom_range(0, 7));
            bus.wr_data  = $urandom;
            bus.rd_addr1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            bus.rd_addr2 = AW'($urandom_range(0, 7));
            #1;
            e1 = exp_rd(bus.rd_addr1);
            e2 = exp_rd(bus.rd_addr2);
            b1 = exp_busy(bus.rd_addr1);
            b2 = exp_busy(bus.rd_addr2);
            n_checks++;
            if (bus.rd_data1 !== e1 || bus.rd_data2 !== e2) begin
                n_fail++; $display("FAIL rand_data cyc%0d: got %h %h expected %h %h",
                                   n, bus.rd_data1, bus.rd_data2, e1, e2);
            end
            n_checks++;
            if (bus.busy1 !== b1 || bus.busy2 !== b2 || bus.hazard !== (b1 | b2)) begin
                n_fail++; $display("FAIL rand_busy cyc%0d: got %b %b %b expected %b %b %b",
                                   n, bus.busy1, bus.busy2, bus.hazard, b1, b2, b1 | b2);
            end
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_issue_write();
        test_same_addr();
        test_r0();
        test_flush();
        test_raw_timing();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
